// File: rtl/result_display_driver.sv
`default_nettype none
// result_display_driver: 8-bit result to 4-digit multiplexed 7-segment display via double-dabble.
// Optional build macro SIGNED_DISPLAY_EN: treat value as two's complement and show a minus on an[3].
module result_display_driver #(
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [2:0]  step_cnt;
  logic [19:0] work, work_next;
  logic [3:0]  hundreds, tens, ones;
  logic [7:0]  magnitude;
  logic        accept, last_step;
  logic [REFRESH_BITS+1:0] refresh_cnt;
  logic [1:0]  sel;

`ifdef SIGNED_DISPLAY_EN
  logic negative, work_neg;
  assign magnitude = value[7] ? (~value + 8'd1) : value;
`else
  assign magnitude = value;
`endif

  // One double-dabble step: {hundreds, tens, ones, binary} with add-3 before the shift.
  function automatic logic [19:0] dabble(input logic [19:0] w);
    logic [19:0] t;
    t = w;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  assign work_next = dabble(work);
  assign busy      = (state == CONVERT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          accept     = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (step_cnt == 3'd7) begin
          last_step  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Visible digits only change on the final step, so a partial conversion is never shown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work     <= '0;
      step_cnt <= '0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
`ifdef SIGNED_DISPLAY_EN
      negative <= 1'b0;
      work_neg <= 1'b0;
`endif
    end else if (accept) begin
      work     <= {12'd0, magnitude};
      step_cnt <= '0;
`ifdef SIGNED_DISPLAY_EN
      work_neg <= value[7];
`endif
    end else if (state == CONVERT) begin
      work     <= work_next;
      step_cnt <= step_cnt + 3'd1;
      if (last_step) begin
        hundreds <= work_next[19:16];
        tens     <= work_next[15:12];
        ones     <= work_next[11:8];
`ifdef SIGNED_DISPLAY_EN
        negative <= work_neg;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) refresh_cnt <= '0;
    else        refresh_cnt <= refresh_cnt + {{(REFRESH_BITS+1){1'b0}}, 1'b1};
  end

  assign sel = refresh_cnt[REFRESH_BITS+1:REFRESH_BITS];
  assign an  = ~(4'b0001 << sel);
  assign dp  = 1'b1;

  always_comb begin
    seg = SEG_BLANK;
    case (sel)
      2'd0: seg = digit_code(ones);
      2'd1: seg = (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : digit_code(tens);
      2'd2: seg = (hundreds == 4'd0) ? SEG_BLANK : digit_code(hundreds);
      2'd3: begin
`ifdef SIGNED_DISPLAY_EN
        seg = negative ? SEG_MINUS : SEG_BLANK;
`else
        seg = SEG_BLANK;
`endif
      end
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_result_display_driver.sv
`default_nettype none
// Scoreboard bench for result_display_driver: stimulus queues expected digit sets, a monitor checks them.
module tb_result_display_driver;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111, MI = 7'b0111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic       load;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected display packed as {an3, an2, an1, an0} segment codes.
  logic [27:0] exp_q[$];

  result_display_driver #(.REFRESH_BITS(2)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One full refresh period (16 cycles at REFRESH_BITS=2) visits every anode.
  task automatic scan(output logic [27:0] got, output logic ok);
    got = 'x;
    ok  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (dp !== 1'b1) ok = 1'b0;
      case (an)
        4'b1110: got[6:0]   = seg;
        4'b1101: got[13:7]  = seg;
        4'b1011: got[20:14] = seg;
        4'b0111: got[27:21] = seg;
        default: ok = 1'b0;
      endcase
    end
  endtask

  initial begin : monitor
    int          busy_len;
    logic        prev;
    logic [27:0] got, e;
    logic        ok;
    busy_len = 0;
    prev     = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        busy_len = 0;
        prev     = 1'b0;
      end else if (busy) begin
        busy_len++;
        prev = 1'b1;
      end else if (prev) begin
        prev = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", busy_len, 32'd8);
          scan(got, ok);
          check("scan_onehot_dp", {31'd0, ok}, 32'd1);
          check("digits", {4'd0, got}, {4'd0, e});
        end
        busy_len = 0;
      end
    end
  end

  task automatic do_load(input logic [7:0] v, input logic [27:0] e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    value = v;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    repeat (30) @(posedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [27:0] got;
    logic        ok;
    reset = 1'b0;
    load  = 1'b0;
    value = 8'd0;
    #2;
    check("reset_an", {28'd0, an}, 32'b1110);
    check("reset_seg", {25'd0, seg}, {25'd0, S0});
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_dp", {31'd0, dp}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_an", {28'd0, an}, 32'b1110);
    reset = 1'b1;
    scan(got, ok);
    check("reset_scan_ok", {31'd0, ok}, 32'd1);
    check("reset_scan", {4'd0, got}, {4'd0, BL, BL, BL, S0});

    do_load(8'd22,  {BL, BL, S2, S2});
`ifdef SIGNED_DISPLAY_EN
    do_load(8'd254, {MI, BL, BL, S2});
    do_load(8'd128, {MI, S1, S2, S8});
    do_load(8'd251, {MI, BL, BL, S5});
    do_load(8'd255, {MI, BL, BL, S1});
`else
    do_load(8'd254, {BL, S2, S5, S4});
    do_load(8'd255, {BL, S2, S5, S5});
`endif
    do_load(8'd100, {BL, S1, S0, S0});
    do_load(8'd9,   {BL, BL, BL, S9});
    do_load(8'd0,   {BL, BL, BL, S0});

    // Second load two cycles into a conversion must be dropped.
    exp_q.push_back({BL, BL, S1, S0});
    @(posedge clk); #1;
    value = 8'd10;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    @(posedge clk); #1;
    value = 8'd99;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    repeat (30) @(posedge clk);

    // Reset in the middle of a conversion.
    @(posedge clk); #1;
    value = 8'd200;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_an", {28'd0, an}, 32'b1110);
    check("abort_seg", {25'd0, seg}, {25'd0, S0});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    scan(got, ok);
    check("abort_scan", {4'd0, got}, {4'd0, BL, BL, BL, S0});
    do_load(8'd7, {BL, BL, BL, S7});

    repeat (10) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
